// File: rtl/core_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_pkg
//  Description : Shared definitions for the core memory port: arbiter state
//                encoding, transaction owner, fetch byte-enable pattern and
//                the instruction size used by the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_mem_pkg;

    // Instruction word size in bytes, shared with the fetch stage.
    localparam int INSTRUCTION_BYTESIZE = 4;

    // Fetches always read a full aligned word.
    localparam logic [3:0] FETCH_BE = 4'hF;

    // Arbiter state encoding (kept as plain constants for legacy tooling).
    localparam logic [1:0] IDLE = 2'd0;   // no transaction
    localparam logic [1:0] REQ  = 2'd1;   // request on the bus, awaiting grant
    localparam logic [1:0] WAIT = 2'd2;   // granted, awaiting response

    // Which port owns the transaction currently in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage : core_mem_pkg
`default_nettype wire

// File: rtl/starve_counter.sv
`default_nettype none
// ============================================================================
//  Module      : starve_counter
//  Description : Saturating counter of consecutive load/store grants taken
//                while fetch is waiting. at_limit tells the arbiter that
//                fetch must win the next arbitration.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk       in   clock, rising edge
//    rst       in   asynchronous reset, active-low
//    inc       in   count one more load/store grant (saturates at limit)
//    clr       in   clear the count (has priority over inc)
//    at_limit  out  count equals STARVE_LIMIT
// ============================================================================
module starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] count;

    assign at_limit = (count == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : starve_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port, variable-latency memory between the
//                instruction fetch path and the load/store path. One
//                transaction in flight at a time; load/store has priority,
//                bounded by a starvation limit that protects fetch. Fetch
//                responses made obsolete by a redirect are discarded, and a
//                transaction without a response is aborted after TIMEOUT
//                wait cycles.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst                    clock (rising edge), async active-low reset
//    if_req_i/if_addr_i          fetch request, held until if_valid_o
//    if_kill_i                   redirect, cancels pending/in-flight fetch
//    if_rdata_o/if_valid_o       fetch response
//    if_stall_o                  StallF
//    ls_req_i/ls_we_i/ls_be_i/
//    ls_addr_i/ls_wdata_i        load/store request, held until ls_valid_o
//    ls_rdata_o/ls_valid_o       load/store completion
//    ls_stall_o                  memory-stage stall
//    err_o                       one-cycle pulse on timeout
//    mem_req_o/we/be/addr/wdata  registered bus request
//    mem_gnt_i/mem_rvalid_i/
//    mem_rdata_i                 bus grant and response
// ============================================================================
module mem_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_kill_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_stall_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [3:0]  ls_be_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic [31:0] ls_rdata_o,
    output logic        ls_valid_o,
    output logic        ls_stall_o,

    output logic        err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [1:0]      state;
    owner_e          owner;
    logic            drop;
    logic [TO_W-1:0] to_cnt;

    logic in_idle;
    logic in_wait;
    logic timed_out;
    logic finish;
    logic if_eligible;
    logic at_limit;
    logic grant_if;
    logic grant_ls;

    assign in_idle = (state == IDLE);
    assign in_wait = (state == WAIT);

    // to_cnt is loaded with 1 on grant, so it equals the WAIT cycle number.
    assign timed_out = in_wait && (to_cnt == TO_W'(TIMEOUT));
    assign finish    = in_wait && (mem_rvalid_i || timed_out);

    // A fetch being redirected this cycle is not allowed to win arbitration.
    assign if_eligible = if_req_i && !if_kill_i;

    // Load/store wins unless fetch has been passed over STARVE_LIMIT times.
    assign grant_ls = in_idle && ls_req_i && !(if_eligible && at_limit);
    assign grant_if = in_idle && if_eligible && !(ls_req_i && !at_limit);

    starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (grant_ls && if_req_i),
        .clr      (grant_if || !if_req_i),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            drop        <= 1'b0;
            to_cnt      <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'h0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    drop   <= 1'b0;
                    to_cnt <= '0;
                    if (grant_ls) begin
                        owner       <= OWN_LS;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= ls_we_i;
                        mem_be_o    <= ls_be_i;
                        mem_addr_o  <= ls_addr_i;
                        mem_wdata_o <= ls_wdata_i;
                        state       <= REQ;
                    end else if (grant_if) begin
                        owner       <= OWN_IF;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= FETCH_BE;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= 32'h0;
                        state       <= REQ;
                    end
                end

                REQ: begin
                    if (if_kill_i && (owner == OWN_IF)) begin
                        drop <= 1'b1;
                    end
                    // The bus fields hold until the grant; the request is never withdrawn.
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        to_cnt    <= TO_W'(1);
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (if_kill_i && (owner == OWN_IF)) begin
                        drop <= 1'b1;
                    end
                    if (finish) begin
                        drop   <= 1'b0;
                        to_cnt <= '0;
                        state  <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A kill arriving together with the response suppresses it as well.
    assign if_valid_o = finish && (owner == OWN_IF) && !drop && !if_kill_i;
    assign ls_valid_o = finish && (owner == OWN_LS);

    // Timeout completions deliver zero data; a real response takes precedence.
    assign if_rdata_o = (if_valid_o && mem_rvalid_i) ? mem_rdata_i : 32'h0;
    assign ls_rdata_o = (ls_valid_o && mem_rvalid_i) ? mem_rdata_i : 32'h0;

    assign err_o = timed_out && !mem_rvalid_i;

    assign if_stall_o = if_req_i & ~if_valid_o;
    assign ls_stall_o = ls_req_i & ~ls_valid_o;

endmodule : mem_port_arbiter
`default_nettype wire
